// File: rtl/uartb_pkg.sv
// uartb_pkg: shared types and constants for the UARTB transmit scheduler.
// Arbitration policy is selected by UARTB_SCHED_RR_EN (see uartb_rr_arb).
package uartb_pkg;

  localparam int DIV_W_DEFAULT = 9;
  localparam int MODE_BIT      = 31;

  localparam logic MODE_NORMAL = 1'b0;
  localparam logic MODE_BURST  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_WAIT,
    S_CFG,
    S_SEND,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic        port;
    logic        burst;
    logic [31:0] data;
  } sel_t;

endpackage

// File: rtl/uartb_rr_arb.sv
// uartb_rr_arb: 2-way arbiter, combinational winner plus last-grant register.
// UARTB_SCHED_RR_EN defined: round-robin; undefined: port 0 fixed priority.
module uartb_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic any,
  output logic win,
  output logic last
);

  assign any = req0 | req1;

`ifdef UARTB_SCHED_RR_EN
  assign win = (req0 && req1) ? ~last : req1;
`else
  assign win = ~req0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      last <= 1'b0;
    else if (take)
      last <= win;
  end

endmodule

// File: rtl/uartb_tx_sched.sv
// uartb_tx_sched: shares the UARTB transmitter between CPU and DMA ports and
// sequences wrbaud/wrtx writes. Arbitration policy: UARTB_SCHED_RR_EN.
module uartb_tx_sched
  import uartb_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic             req0_burst,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic             req1_burst,
  input  logic [DIV_W-1:0] cfg_divider,
  input  logic             uart_thre,
  input  logic             uart_tend,
  output logic [31:0]      uart_d,
  output logic             uart_wrtx,
  output logic             uart_wrbaud,
  output logic             grant,
  output logic             busy
);

  state_t           state;
  state_t           next;
  sel_t             sel;
  logic             cur_mode;
  logic [DIV_W-1:0] cur_div;
  logic             cfg_pending;

  logic             any;
  logic             win;
  logic             take;
  logic             win_burst;
  logic [31:0]      win_data;
  logic             need_cfg;
  logic [31:0]      cfg_word;
  logic [31:0]      tx_word;

  logic [31:0]      d_nx;
  logic             wrtx_nx;
  logic             wrbaud_nx;
  logic             rdy0_nx;
  logic             rdy1_nx;

  assign take      = (state == S_IDLE) && any;
  assign win_burst = win ? req1_burst : req0_burst;
  assign win_data  = win ? req1_data : req0_data;

  // Compare against cur_div directly so a divider change is seen at once
  assign need_cfg = cfg_pending
                  | (cfg_divider != cur_div)
                  | (win_burst != cur_mode);

  uartb_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .take (take),
    .any  (any),
    .win  (win),
    .last (grant)
  );

  always_comb begin
    cfg_word = '0;
    cfg_word[DIV_W-1:0] = cfg_divider;
    cfg_word[MODE_BIT] = sel.burst;
  end

  assign tx_word = (sel.burst == MODE_BURST)
                 ? sel.data
                 : {24'h0, sel.data[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sel         <= '0;
      cur_mode    <= MODE_NORMAL;
      cur_div     <= '0;
      cfg_pending <= 1'b1;
    end else begin
      state <= next;
      if (take)
        sel <= '{port: win, burst: win_burst, data: win_data};
      if (state == S_CFG) begin
        cur_mode    <= sel.burst;
        cur_div     <= cfg_divider;
        cfg_pending <= 1'b0;
      end else if (cfg_divider != cur_div) begin
        cfg_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:
        if (any)
          next = need_cfg ? S_CFG_WAIT : S_SEND;
      S_CFG_WAIT:
        if (uart_tend && uart_thre)
          next = S_CFG;
      S_CFG:
        next = S_SEND;
      S_SEND:
        if (uart_thre)
          next = S_HOLD;
      S_HOLD:
        next = S_IDLE;
      default:
        next = S_IDLE;
    endcase
  end

  always_comb begin
    d_nx      = uart_d;
    wrtx_nx   = 1'b0;
    wrbaud_nx = 1'b0;
    rdy0_nx   = 1'b0;
    rdy1_nx   = 1'b0;
    if (state == S_CFG) begin
      wrbaud_nx = 1'b1;
      d_nx      = cfg_word;
    end
    if ((state == S_SEND) && uart_thre) begin
      wrtx_nx = 1'b1;
      d_nx    = tx_word;
      rdy0_nx = ~sel.port;
      rdy1_nx = sel.port;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_d      <= '0;
      uart_wrtx   <= 1'b0;
      uart_wrbaud <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      uart_d      <= d_nx;
      uart_wrtx   <= wrtx_nx;
      uart_wrbaud <= wrbaud_nx;
      req0_ready  <= rdy0_nx;
      req1_ready  <= rdy1_nx;
      busy        <= (next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uartb_tx_sched.sv
// tb_uartb_tx_sched: scoreboard bench for uartb_tx_sched with a small UART
// line model (holding register plus shifter with a fixed character time).
module tb_uartb_tx_sched;

  localparam int CHAR = 12;

  typedef struct {
    bit          baud;
    bit          port;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_burst;
  logic        req1_valid, req1_ready, req1_burst;
  logic [31:0] req0_data, req1_data;
  logic [8:0]  cfg_divider;
  logic        uart_thre, uart_tend;
  logic [31:0] uart_d;
  logic        uart_wrtx, uart_wrbaud, grant, busy;

  int total = 0;
  int passed = 0;

  exp_t exp_q[$];

  bit         m_pend = 1'b1;
  bit         m_mode = 1'b0;
  bit         m_last = 1'b0;
  logic [8:0] m_div = '0;

  logic hr_full = 1'b0;
  int   m_cnt = 0;
  logic thre_hold = 1'b0;

  always #5 clk = ~clk;

  uartb_tx_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_data   (req0_data),
    .req0_burst  (req0_burst),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_data   (req1_data),
    .req1_burst  (req1_burst),
    .cfg_divider (cfg_divider),
    .uart_thre   (uart_thre),
    .uart_tend   (uart_tend),
    .uart_d      (uart_d),
    .uart_wrtx   (uart_wrtx),
    .uart_wrbaud (uart_wrbaud),
    .grant       (grant),
    .busy        (busy)
  );

  // UART model: wrtx fills the holding register, which then feeds the shifter
  always @(posedge clk) begin
    if (uart_wrtx === 1'b1)
      hr_full <= 1'b1;
    else if (hr_full && m_cnt == 0) begin
      hr_full <= 1'b0;
      m_cnt   <= CHAR;
    end else if (m_cnt != 0)
      m_cnt <= m_cnt - 1;
  end

  assign uart_thre = !hr_full && !thre_hold;
  assign uart_tend = !hr_full && (m_cnt == 0);

  always @(negedge clk) begin
    exp_t        e;
    logic [36:0] act, req;
    if (uart_wrtx === 1'b1 || uart_wrbaud === 1'b1) begin
      total++;
      act = {uart_wrbaud, uart_wrtx, req1_ready, req0_ready, grant, uart_d};
      if (exp_q.size() == 0) begin
        $display("FAIL strobe: got %h, required no strobe", act);
      end else begin
        e = exp_q.pop_front();
        req = {e.baud, !e.baud, !e.baud && e.port, !e.baud && !e.port,
               e.port, e.d};
        if (act !== req)
          $display("FAIL strobe: got %h, required %h", act, req);
        else
          passed++;
      end
      total++;
      if ((uart_wrbaud === 1'b1 && (m_cnt != 0 || hr_full)) ||
          (uart_wrtx === 1'b1 && hr_full))
        $display("FAIL line: wrbaud=%b wrtx=%b cnt=%0d hr=%b, required idle",
                 uart_wrbaud, uart_wrtx, m_cnt, hr_full);
      else
        passed++;
    end else if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
      total++;
      $display("FAIL ready: got %b%b without wrtx, required 00",
               req1_ready, req0_ready);
    end
  end

  function automatic void expect_xfer(input bit p, input logic [31:0] w,
                                      input bit b);
    exp_t e;
    if (m_pend || cfg_divider != m_div || b != m_mode) begin
      e.baud = 1'b1;
      e.port = p;
      e.d    = {b, 22'h0, cfg_divider};
      exp_q.push_back(e);
      m_pend = 1'b0;
      m_div  = cfg_divider;
      m_mode = b;
    end
    e.baud = 1'b0;
    e.port = p;
    e.d    = b ? w : {24'h0, w[7:0]};
    exp_q.push_back(e);
    m_last = p;
  endfunction

  task automatic drive(input bit p, input logic [31:0] w, input bit b,
                       input bit v);
    if (p) begin
      req1_data = w; req1_burst = b; req1_valid = v;
    end else begin
      req0_data = w; req0_burst = b; req0_valid = v;
    end
  endtask

  task automatic wait_ready(input bit p, output bit got);
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = p ? (req1_ready === 1'b1) : (req0_ready === 1'b1);
    end
  endtask

  task automatic xfer(input bit p, input logic [31:0] w, input bit b);
    bit got;
    expect_xfer(p, w, b);
    drive(p, w, b, 1'b1);
    wait_ready(p, got);
    total++;
    if (!got) $display("FAIL xfer_ready: port %0d got no ready, required 1", p);
    else passed++;
    drive(p, w, b, 1'b0);
  endtask

  task automatic test_reset();
    logic [38:0] act;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_data = '0; req1_data = '0;
    req0_burst = 0; req1_burst = 0;
    cfg_divider = 9'd7;
    repeat (3) @(negedge clk);
    act = {req0_ready, req1_ready, uart_wrtx, uart_wrbaud, grant, busy,
           1'b0, uart_d};
    total++;
    if (act !== 39'h0) $display("FAIL reset: got %h, required 0", act);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy);
    else passed++;
  endtask

  task automatic test_normal();
    bit got;
    int n;
    xfer(0, 32'h0000_0041, 0);
    repeat (3) @(negedge clk);
    expect_xfer(0, 32'h0000_0042, 0);
    drive(0, 32'h0000_0042, 0, 1'b1);
    n = 0; got = 0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      if (uart_wrtx === 1'b1) begin got = 1; n = k; end
    end
    total++;
    if (n != 2) $display("FAIL latency: got %0d cycles, required 2", n);
    else passed++;
    drive(0, 32'h0000_0042, 0, 1'b0);
  endtask

  task automatic test_thre_hold();
    bit seen, got;
    repeat (3) @(negedge clk);
    thre_hold = 1'b1;
    expect_xfer(0, 32'h0000_0043, 0);
    drive(0, 32'h0000_0043, 0, 1'b1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (uart_wrtx === 1'b1) seen = 1;
    end
    total++;
    if (seen || busy !== 1'b1)
      $display("FAIL thre_wait: wrtx_seen=%b busy=%b, required 0/1", seen, busy);
    else passed++;
    thre_hold = 1'b0;
    wait_ready(0, got);
    total++;
    if (!got) $display("FAIL thre_release: got no ready, required 1");
    else passed++;
    drive(0, 32'h0000_0043, 0, 1'b0);
  endtask

  task automatic test_burst_cfg_wait();
    bit got;
    xfer(0, 32'h0000_0045, 0);
    expect_xfer(1, 32'h4443_4241, 1);
    drive(1, 32'h4443_4241, 1, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1 || uart_wrbaud !== 1'b0)
      $display("FAIL cfg_wait: busy=%b wrbaud=%b, required 1/0", busy, uart_wrbaud);
    else passed++;
    wait_ready(1, got);
    total++;
    if (!got) $display("FAIL burst_ready: got no ready1, required 1");
    else passed++;
    drive(1, 32'h4443_4241, 1, 1'b0);
  endtask

  task automatic test_arbitration();
    logic [31:0] dv [2];
    bit          w, got, gp;
    dv[0] = 32'h0000_0061;
    dv[1] = 32'h0000_0071;
    req0_burst = 0; req1_burst = 0;
    req0_data = dv[0]; req1_data = dv[1];
`ifdef UARTB_SCHED_RR_EN
    w = !m_last;
`else
    w = 1'b0;
`endif
    expect_xfer(w, dv[w], 0);
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      got = 0; gp = 0;
      for (int n = 0; n < 300 && !got; n++) begin
        @(negedge clk);
        got = (req0_ready === 1'b1) || (req1_ready === 1'b1);
        gp  = (req1_ready === 1'b1);
      end
      total++;
      if (!got || gp != w)
        $display("FAIL arb_%0d: got port %0d (ready=%b), required %0d", k, gp, got, w);
      else passed++;
      dv[gp] = dv[gp] + 1;
      req0_data = dv[0]; req1_data = dv[1];
      if (k < 3) begin
`ifdef UARTB_SCHED_RR_EN
        w = !m_last;
`else
        w = 1'b0;
`endif
        expect_xfer(w, dv[w], 0);
      end
    end
    req0_valid = 0;
    expect_xfer(1, dv[1], 0);
    wait_ready(1, got);
    total++;
    if (!got) $display("FAIL arb_tail: got no ready1, required 1");
    else passed++;
    req1_valid = 0;
  endtask

  task automatic test_divider_change();
    repeat (2) @(negedge clk);
    cfg_divider = 9'd3;
    repeat (2) @(negedge clk);
    xfer(0, 32'h0000_0046, 0);
  endtask

  task automatic test_reset_mid();
    logic [38:0] act;
    repeat (20) @(negedge clk);
    thre_hold = 1'b1;
    drive(0, 32'h0000_0055, 0, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL send_hold: busy=%b, required 1", busy);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    act = {req0_ready, req1_ready, uart_wrtx, uart_wrbaud, grant, busy,
           1'b0, uart_d};
    total++;
    if (act !== 39'h0) $display("FAIL reset_mid: got %h, required 0", act);
    else passed++;
    rst = 1'b0;
    drive(0, 32'h0000_0055, 0, 1'b0);
    thre_hold = 1'b0;
    m_pend = 1'b1; m_mode = 1'b0; m_div = '0; m_last = 1'b0;
    repeat (3) @(negedge clk);
    xfer(0, 32'h0000_005A, 0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_thre_hold();
    test_burst_cfg_wait();
    test_arbitration();
    test_divider_change();
    test_reset_mid();
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
